// File: rtl/pc_trace_buffer_pkg.sv
// Shared definitions for the PC trace buffer. These cover the widths, the entry
// kinds, the packed entry layout and the compressor states.
package pc_trace_buffer_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned RUN_W   = 8;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned PC_STEP = 1;
  localparam int unsigned LVL_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = 2 + PC_W + RUN_W;

  localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};

  typedef enum logic [1:0] {
    KIND_SYNC = 2'b00,
    KIND_JUMP = 2'b01,
    KIND_SAT  = 2'b10,
    KIND_STOP = 2'b11
  } kind_e;

  // The field order fixes the bit layout: kind is the MSBs, then pc, then run.
  typedef struct packed {
    kind_e             kind;
    logic [PC_W-1:0]   pc;
    logic [RUN_W-1:0]  run;
  } entry_t;

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_SYNC = 2'b01,
    ST_RUN  = 2'b10
  } state_e;

endpackage

// File: rtl/pc_trace_buffer_if.sv
// Trace drain port carrying a valid/ready head of the trace FIFO.
//   master: the buffer drives valid/kind/pc/run and samples ready.
//   slave : the debug host drives ready.
interface pc_trace_buffer_if;
  import pc_trace_buffer_pkg::*;

  logic             valid;
  logic             ready;
  kind_e            kind;
  logic [PC_W-1:0]  pc;
  logic [RUN_W-1:0] run;

  modport master (output valid, kind, pc, run, input ready);
  modport slave  (input valid, kind, pc, run, output ready);
endinterface

// File: rtl/pc_trace_buffer_sync_fifo.sv
// First-word-fall-through synchronous FIFO with an occupancy count.
//   clk, rst  : clock and synchronous active-high reset (flushes the FIFO)
//   push, din : write request and data. The write is accepted when the FIFO is
//               not full, or when it is full and a pop occurs on the same edge.
//   pop       : read request. A pop while empty is ignored.
//   dout      : head word. It is valid while empty is 0.
//   full, empty, count : occupancy status
module pc_trace_buffer_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr_q];
  assign count   = count_q;

  // Storage array. It needs no reset because reads are qualified by count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pc_trace_buffer.sv
// PC trace compressor. It samples the core PC every clock and emits entries of
// the form {kind, pc, run} into a FIFO that the debug host drains. The block only
// observes the core and never stalls it.
//   clk, rst  : clock and synchronous active-high reset
//   pc        : core PC, sampled on every edge
//   trace_en  : capture enable
//   clr_ovf   : clears the sticky overflow flag. A drop on the same edge wins.
//   trace     : drain port (valid/ready head of the FIFO)
//   level     : FIFO occupancy
//   overflow  : sticky flag, set when an entry is dropped
module pc_trace_buffer
  import pc_trace_buffer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc,
  input  logic               trace_en,
  input  logic               clr_ovf,
  pc_trace_buffer_if.master  trace,
  output logic [LVL_W-1:0]   level,
  output logic               overflow
);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  prev_pc_q, prev_pc_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             overflow_q;

  logic             gen;
  entry_t           gen_entry;
  logic             drop;
  logic             seq;

  logic             fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_dout;
  entry_t           head;

  assign seq = (pc == prev_pc_q + PC_W'(PC_STEP));

  // Compressor FSM. It produces next state, run/prev_pc updates and the entry to push.
  always_comb begin
    state_d   = state_q;
    prev_pc_d = prev_pc_q;
    run_d     = run_q;
    gen       = 1'b0;
    gen_entry = '{kind: KIND_SYNC, pc: '0, run: '0};
    drop      = 1'b0;

    case (state_q)
      ST_OFF: begin
        if (trace_en) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (trace_en) begin
          gen       = 1'b1;
          gen_entry = '{kind: KIND_SYNC, pc: pc, run: '0};
          prev_pc_d = pc;
          run_d     = '0;
          state_d   = ST_RUN;
        end else begin
          state_d   = ST_OFF;
        end
      end
      ST_RUN: begin
        if (trace_en) begin
          prev_pc_d = pc;
          if (seq && (run_q != RUN_MAX)) begin
            run_d = run_q + RUN_W'(1);
          end else if (seq) begin
            gen       = 1'b1;
            gen_entry = '{kind: KIND_SAT, pc: pc, run: RUN_MAX};
            run_d     = '0;
          end else begin
            gen       = 1'b1;
            gen_entry = '{kind: KIND_JUMP, pc: pc, run: run_q};
            run_d     = '0;
          end
        end else begin
          gen       = 1'b1;
          gen_entry = '{kind: KIND_STOP, pc: prev_pc_q, run: run_q};
          run_d     = '0;
          state_d   = ST_OFF;
        end
      end
      default: state_d = ST_OFF;
    endcase

    // A full FIFO with no pop loses the entry, so the next one must re-anchor the PC.
    // "full" implies "not empty", so the pop here reduces to ready.
    drop = gen && fifo_full && !trace.ready;
    if (drop) state_d = ST_SYNC;
  end

  // Compressor state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_OFF;
      prev_pc_q <= '0;
      run_q     <= '0;
    end else begin
      state_q   <= state_d;
      prev_pc_q <= prev_pc_d;
      run_q     <= run_d;
    end
  end

  // Sticky overflow flag. A set on this edge takes priority over a clear.
  always_ff @(posedge clk) begin
    if (rst)          overflow_q <= 1'b0;
    else if (drop)    overflow_q <= 1'b1;
    else if (clr_ovf) overflow_q <= 1'b0;
  end

  pc_trace_buffer_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (gen),
    .din   (gen_entry),
    .pop   (trace.ready),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (level)
  );

  assign head = fifo_dout;

  // The head fields read as zero while the FIFO is empty, because the storage is not reset.
  assign trace.valid = !fifo_empty;
  assign trace.kind  = fifo_empty ? KIND_SYNC : head.kind;
  assign trace.pc    = fifo_empty ? '0 : head.pc;
  assign trace.run   = fifo_empty ? '0 : head.run;
  assign overflow    = overflow_q;

endmodule
